// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
// Six packed BCD digits feed the display stage directly.
package seg_pkg;
    localparam int          BCD_DIGITS = 6;
    localparam int          BCD_W      = BCD_DIGITS * 4;
    localparam logic [31:0] BCD_MAX    = 32'd999999;
    localparam logic [23:0] BCD_SAT    = 24'h999999;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } conv_state_t;
endpackage

// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between a client and the binary-to-BCD converter.
// The client drives start and bin_in; the converter returns status and digits.
interface bin_to_bcd_if #(
    parameter int BIN_W = 20
);
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [23:0]      bcd_out;
    logic             ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one input bit per clock, BIN_W shifts
// per conversion, saturating at 999999 with an overflow flag.
module bin_to_bcd
    import seg_pkg::*;
#(
    parameter int BIN_W = 20
) (
    input  logic         clk,
    input  logic         rst,
    bin_to_bcd_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t      r_state;
    conv_state_t      w_stateNext;
    logic [BIN_W-1:0] r_bin;
    logic [BIN_W-1:0] w_binNext;
    logic [BCD_W-1:0] r_acc;
    logic [BCD_W-1:0] w_accNext;
    logic [BCD_W-1:0] w_accAdj;
    logic [BCD_W-1:0] w_accShifted;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_big;
    logic             w_bigNext;
    logic [23:0]      r_bcd;
    logic [23:0]      w_bcdNext;
    logic             r_ovf;
    logic             w_ovfNext;
    logic             r_done;
    logic             w_doneNext;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc[4*g +: 4]),
            .o_digit (w_accAdj[4*g +: 4])
        );
    end

    // The top accumulator bit shifted out is only non-zero for values above
    // 999999, which are replaced by the saturated code anyway.
    assign w_accShifted = {w_accAdj[BCD_W-2:0], r_bin[BIN_W-1]};

    always_comb begin
        w_stateNext = r_state;
        w_binNext   = r_bin;
        w_accNext   = r_acc;
        w_cntNext   = r_cnt;
        w_bigNext   = r_big;
        w_bcdNext   = r_bcd;
        w_ovfNext   = r_ovf;
        w_doneNext  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_binNext   = bus.bin_in;
                    w_accNext   = '0;
                    w_cntNext   = '0;
                    w_bigNext   = (32'(bus.bin_in) > BCD_MAX);
                    w_stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_accNext = w_accShifted;
                w_binNext = r_bin << 1;
                w_cntNext = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_bcdNext   = r_big ? BCD_SAT : w_accShifted;
                    w_ovfNext   = r_big;
                    w_doneNext  = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_big   <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_bin   <= w_binNext;
            r_acc   <= w_accNext;
            r_cnt   <= w_cntNext;
            r_big   <= w_bigNext;
            r_bcd   <= w_bcdNext;
            r_ovf   <= w_ovfNext;
            r_done  <= w_doneNext;
        end
    end

    assign bus.busy    = (r_state == ST_SHIFT);
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd;
    assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: a decimal reference model predicts each
// result, a negedge monitor pops and compares whenever done is presented.
module tb_bin_to_bcd;
    localparam int BIN_W = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bin_to_bcd_if #(.BIN_W(BIN_W)) bus ();
    bin_to_bcd_if #(.BIN_W(14))    bus14 ();

    bin_to_bcd #(.BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bin_to_bcd #(.BIN_W(14)) dut14 (
        .clk (clk),
        .rst (rst),
        .bus (bus14)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] expQ[$];
    int          busyLeft = 0;
    logic        doneExp = 1'b0;
    logic        accepted = 1'b0;
    logic [23:0] lastBcd = '0;
    logic        lastOvf = 1'b0;

    // Reference: plain decimal digit extraction, saturating above 999999.
    function automatic logic [24:0] refConv(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return {1'b1, 24'h999999};
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model tracks acceptance and completion timing.
    task automatic applyStimulus(input logic s, input logic [BIN_W-1:0] b);
        @(negedge clk);
        #1;
        bus.start  = s;
        bus.bin_in = b;
        @(posedge clk);
        doneExp  = (busyLeft == 1);
        accepted = 1'b0;
        if (busyLeft == 0 && s) begin
            expQ.push_back(refConv(32'(b)));
            busyLeft = BIN_W;
            accepted = 1'b1;
        end else if (busyLeft != 0) begin
            busyLeft--;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2;
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.bin_in = 20'($urandom);
        expQ.delete();
        busyLeft = 0;
        doneExp  = 1'b0;
        lastBcd  = '0;
        lastOvf  = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_bcd",  32'(bus.bcd_out), 32'd0);
        checkOutput("rst_ovf",  32'(bus.ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst       = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic convertOne(input logic [BIN_W-1:0] v);
        applyStimulus(1'b1, v);
        repeat (BIN_W + 2) applyStimulus(1'b0, 20'($urandom));
    endtask

    always @(negedge clk) begin
        logic [24:0] e;
        checkOutput("busy", 32'(bus.busy), 32'(busyLeft != 0));
        checkOutput("done_timing", 32'(bus.done), 32'(doneExp));
        if (bus.done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("bcd_out", {8'h0, bus.bcd_out}, {8'h0, e[23:0]});
                checkOutput("ovf", 32'(bus.ovf), 32'(e[24]));
                lastBcd = e[23:0];
                lastOvf = e[24];
            end
        end else begin
            checkOutput("bcd_hold", {8'h0, bus.bcd_out}, {8'h0, lastBcd});
            checkOutput("ovf_hold", 32'(bus.ovf), 32'(lastOvf));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned cur;
        int          n;
        bus.start    = 1'b0;
        bus.bin_in   = '0;
        bus14.start  = 1'b0;
        bus14.bin_in = '0;

        applyReset();
        repeat (2) applyStimulus(1'b0, '0);

        convertOne(20'd0);
        convertOne(20'd123456);
        convertOne(20'd999999);
        convertOne(20'd1000000);
        convertOne(20'd1048575);
        convertOne(20'd42);

        // Start held high: only idle-cycle starts are taken, values 1,2,3.
        cur = 1;
        for (int i = 0; i < 3 * (BIN_W + 1); i++) begin
            applyStimulus(1'b1, 20'(cur));
            if (accepted) cur++;
        end
        repeat (BIN_W + 2) applyStimulus(1'b0, '0);
        checkOutput("held_start_count", cur, 32'd4);

        // Reset in the middle of a conversion abandons it.
        applyStimulus(1'b1, 20'd654321);
        repeat (9) applyStimulus(1'b0, '0);
        applyReset();
        repeat (BIN_W + 2) applyStimulus(1'b0, '0);
        convertOne(20'd654321);

        for (int i = 0; i < 1500; i++) begin
            logic [BIN_W-1:0] v;
            case ($urandom_range(0, 3))
                0: v = 20'($urandom_range(0, 99));
                1: v = 20'($urandom_range(999990, 1000010));
                default: v = 20'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 3) == 0), v);
        end
        repeat (BIN_W + 3) applyStimulus(1'b0, '0);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        // Narrow instance: 14 shifts per conversion.
        @(negedge clk);
        bus14.start  = 1'b1;
        bus14.bin_in = 14'd9999;
        @(posedge clk);
        @(negedge clk);
        bus14.start = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus14.done) break;
        end
        checkOutput("w14_latency", 32'(n), 32'd14);
        checkOutput("w14_done", 32'(bus14.done), 32'd1);
        checkOutput("w14_bcd", {8'h0, bus14.bcd_out}, 32'h009999);
        checkOutput("w14_ovf", 32'(bus14.ovf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
